// File: rtl/conv_1st_pkg.sv
// conv_1st_pkg
//   Shared definitions for the first-layer convolution frame scheduler:
//   the scheduler state encoding, the out-of-range "idle" pointer values
//   that make a scan/bias write a no-op in the engine, and the word widths
//   used on the host, engine and downstream sides.
package conv_1st_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_BIAS,
    ST_LOAD_PIX,
    ST_SETTLE,
    ST_RUN
  } state_t;

  // Pointers beyond the last buffer entry; the engine ignores these writes.
  localparam logic [6:0] SCAN_PTR_IDLE = 7'h7F;
  localparam logic [5:0] BIAS_PTR_IDLE = 6'h3F;

  localparam int PIX_W  = 32;
  localparam int BIAS_W = 16;
  localparam int BEAT_W = 320;

endpackage

// File: rtl/conv_1st_ofifo.sv
// conv_1st_ofifo
//   Small synchronous FIFO for engine output beats. The head entry is held
//   in a dedicated output register so dout is a clean flop output; it reads
//   0 whenever the FIFO is empty. Pushes while full are accepted only when a
//   pop happens in the same cycle; otherwise the caller's beat is dropped.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push, din    write request and data
//   pop          read request (ignored when empty)
//   dout         registered head entry
//   full, empty  occupancy flags
module conv_1st_ofifo #(
  parameter int WIDTH = 320,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;
  logic [WIDTH-1:0] head_next;

  assign empty      = (count == '0);
  assign full       = (count == CNT_FULL);
  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);
  assign rd_next    = rd_ptr + AW'(do_pop);
  assign count_next = count + (AW+1)'(do_push) - (AW+1)'(do_pop);

  // Next head value: if the FIFO is empty after this cycle's pop, a push
  // goes straight to the head register because it is not yet in storage.
  always_comb begin
    head_next = mem[rd_next];
    if (count_next == '0) begin
      head_next = '0;
    end else if (count == (AW+1)'(do_pop)) begin
      head_next = din;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_next;
      count  <= count_next;
      dout   <= head_next;
    end
  end

endmodule

// File: rtl/conv_1st_sched.sv
// conv_1st_sched
//   Frame scheduler for the first-layer convolution engine. Host words are
//   turned into pointer-tagged bias and scan-chain writes, the engine start
//   level is held for the frame, and engine output beats are buffered in
//   conv_1st_ofifo and drained under valid/ready.
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   frame_req, bias_reload    frame start (IDLE only) and bias reload select
//   busy_o                    state is not IDLE
//   cfg_valid/ready/data      host word stream
//   scan_o, bias_o            engine scan and bias writes (idle ptr = no write)
//   sta_o                     engine start level
//   conv_valid_i, conv_i      engine output beats
//   out_valid/ready/data      downstream beat stream
//   done_o                    pulse with the last beat of a frame
//   ovf_o                     sticky dropped-beat flag
// Build option:
//   CONV_1ST_SCHED_OVF_EN     builds the overflow detector; otherwise ovf_o=0
module conv_1st_sched
  import conv_1st_pkg::*;
#(
  parameter int PIX_WORDS   = 75,
  parameter int BIAS_WORDS  = 34,
  parameter int OUT_BEATS   = 32,
  parameter int OFIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_req,
  input  logic              bias_reload,
  output logic              busy_o,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [PIX_W-1:0]  cfg_data,
  output logic [PIX_W+7:0]  scan_o,
  output logic [BIAS_W+7:0] bias_o,
  output logic              sta_o,
  input  logic              conv_valid_i,
  input  logic [BEAT_W-1:0] conv_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BEAT_W-1:0] out_data,
  output logic              done_o,
  output logic              ovf_o
);

  localparam int BEAT_CW = $clog2(OUT_BEATS + 1);
  localparam logic [6:0]         PIX_LAST  = 7'(PIX_WORDS - 1);
  localparam logic [6:0]         BIAS_LAST = 7'(BIAS_WORDS - 1);
  localparam logic [BEAT_CW-1:0] BEAT_LAST = BEAT_CW'(OUT_BEATS - 1);
  localparam logic [PIX_W+7:0]   SCAN_IDLE = {32'h0, 1'b0, SCAN_PTR_IDLE};
  localparam logic [BIAS_W+7:0]  BIAS_IDLE = {16'h0, 2'b00, BIAS_PTR_IDLE};

  state_t             state;
  logic [6:0]         word_cnt;
  logic [BEAT_CW-1:0] beat_cnt;
  logic               cfg_xfer;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic               last_beat;

  assign cfg_xfer  = cfg_valid && cfg_ready;
  assign fifo_push = (state == ST_RUN) && conv_valid_i;
  // Dropped beats still count, so the frame always ends at OUT_BEATS.
  assign last_beat = fifo_push && (beat_cnt == BEAT_LAST);
  assign done_o    = last_beat;
  assign out_valid = !fifo_empty;
  assign fifo_pop  = out_valid && out_ready;

  // Frame sequencer. scan_o/bias_o default to their idle pointer every
  // cycle so each accepted word shows up as a single-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      word_cnt  <= '0;
      beat_cnt  <= '0;
      cfg_ready <= 1'b0;
      busy_o    <= 1'b0;
      sta_o     <= 1'b0;
      scan_o    <= SCAN_IDLE;
      bias_o    <= BIAS_IDLE;
    end else begin
      scan_o <= SCAN_IDLE;
      bias_o <= BIAS_IDLE;
      case (state)
        ST_IDLE: begin
          if (frame_req) begin
            word_cnt  <= '0;
            beat_cnt  <= '0;
            cfg_ready <= 1'b1;
            busy_o    <= 1'b1;
            state     <= bias_reload ? ST_LOAD_BIAS : ST_LOAD_PIX;
          end
        end
        ST_LOAD_BIAS: begin
          if (cfg_xfer) begin
            bias_o <= {cfg_data[BIAS_W-1:0], 2'b00, word_cnt[5:0]};
            if (word_cnt == BIAS_LAST) begin
              word_cnt <= '0;
              state    <= ST_LOAD_PIX;
            end else begin
              word_cnt <= word_cnt + 7'd1;
            end
          end
        end
        ST_LOAD_PIX: begin
          if (cfg_xfer) begin
            scan_o <= {cfg_data, 1'b0, word_cnt};
            if (word_cnt == PIX_LAST) begin
              cfg_ready <= 1'b0;
              state     <= ST_SETTLE;
            end else begin
              word_cnt <= word_cnt + 7'd1;
            end
          end
        end
        ST_SETTLE: begin
          sta_o <= 1'b1;
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (fifo_push) begin
            if (last_beat) begin
              beat_cnt <= '0;
              sta_o    <= 1'b0;
              busy_o   <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              beat_cnt <= beat_cnt + BEAT_CW'(1);
            end
          end
        end
        default: begin
          cfg_ready <= 1'b0;
          busy_o    <= 1'b0;
          sta_o     <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  conv_1st_ofifo #(
    .WIDTH (BEAT_W),
    .DEPTH (OFIFO_DEPTH)
  ) u_ofifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (conv_i),
    .dout  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef CONV_1ST_SCHED_OVF_EN
  logic ovf_q;

  // Sticky flag: a push into a full FIFO with no pop loses the beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (fifo_push && fifo_full && !fifo_pop) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_o = ovf_q;
`else
  // The full flag is only needed by the overflow detector.
  logic full_unused;
  assign full_unused = fifo_full;
  assign ovf_o       = 1'b0;
`endif

endmodule

// File: tb/tb_conv_1st_sched.sv
// tb_conv_1st_sched
//   Scoreboard bench for conv_1st_sched. Stimulus tasks push the expected
//   scan/bias writes and downstream beats into queues; a monitor on the
//   falling edge pops and compares whenever the DUT presents them.
module tb_conv_1st_sched;

  localparam int PIX_WORDS  = 75;
  localparam int BIAS_WORDS = 34;
  localparam int OUT_BEATS  = 32;
  localparam logic [39:0] SCAN_IDLE = {32'h0, 1'b0, 7'h7F};
  localparam logic [23:0] BIAS_IDLE = {16'h0, 2'b00, 6'h3F};

  logic         clk;
  logic         rst_n;
  logic         frame_req;
  logic         bias_reload;
  logic         busy_o;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [31:0]  cfg_data;
  logic [39:0]  scan_o;
  logic [23:0]  bias_o;
  logic         sta_o;
  logic         conv_valid_i;
  logic [319:0] conv_i;
  logic         out_valid;
  logic         out_ready;
  logic [319:0] out_data;
  logic         done_o;
  logic         ovf_o;

  int testsRun;
  int testsFailed;
  bit ovfDropExpect;

  logic [39:0]  scanQ[$];
  logic [23:0]  biasQ[$];
  logic [319:0] outQ[$];

  conv_1st_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_req    (frame_req),
    .bias_reload  (bias_reload),
    .busy_o       (busy_o),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_data     (cfg_data),
    .scan_o       (scan_o),
    .bias_o       (bias_o),
    .sta_o        (sta_o),
    .conv_valid_i (conv_valid_i),
    .conv_i       (conv_i),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .done_o       (done_o),
    .ovf_o        (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pixWord(input int f, input int k);
    return {8'hA0, 8'(f), 16'(k)};
  endfunction

  function automatic logic [31:0] biasWord(input int f, input int k);
    return {8'h5A, 8'(f), 8'(k * 3), 8'(~k)};
  endfunction

  function automatic logic [319:0] beatPattern(input int f, input int k);
    logic [7:0] b;
    b = 8'(f * 32 + k);
    return {40{b}};
  endfunction

  task automatic checkOutput(input string name, input logic [319:0] actual,
                             input logic [319:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Present one host word and wait (bounded) for it to be accepted.
  task automatic applyStimulus(input logic [31:0] d, input bit isBias, input int idx);
    bit ok;
    int waitCnt;
    cfg_valid = 1'b1;
    cfg_data  = d;
    ok        = 1'b0;
    waitCnt   = 0;
    while (!ok && waitCnt < 50) begin
      @(negedge clk);
      ok = cfg_ready;
      @(posedge clk);
      #1;
      waitCnt++;
    end
    cfg_valid = 1'b0;
    checkOutput("cfg_accept", 320'(ok), 320'(1));
    if (ok) begin
      if (isBias) biasQ.push_back({d[15:0], 2'b00, 6'(idx)});
      else        scanQ.push_back({d, 1'b0, 7'(idx)});
    end
  endtask

  task automatic startFrame(input bit reload);
    frame_req   = 1'b1;
    bias_reload = reload;
    @(posedge clk);
    #1;
    frame_req   = 1'b0;
    bias_reload = 1'b0;
  endtask

  task automatic loadFrame(input int f, input bit reload, input bit toggle, input int nPix);
    startFrame(reload);
    if (reload) begin
      for (int k = 0; k < BIAS_WORDS; k++) applyStimulus(biasWord(f, k), 1'b1, k);
    end
    for (int k = 0; k < nPix; k++) begin
      applyStimulus(pixWord(f, k), 1'b0, k);
      if (toggle && k != nPix - 1) begin
        cfg_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
      end
    end
  endtask

  // SETTLE cycle after the last scan write, then sta_o rises.
  task automatic checkStart();
    @(negedge clk);
    checkOutput("settle_sta_low", 320'(sta_o), 320'(0));
    checkOutput("settle_busy", 320'(busy_o), 320'(1));
    checkOutput("settle_cfg_ready", 320'(cfg_ready), 320'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("sta_rise", 320'(sta_o), 320'(1));
    @(posedge clk);
    #1;
  endtask

  // OUT_BEATS engine beats; out_ready held low for the first 'hold' beats.
  // Starting from an empty depth-4 FIFO, only beats 0..3 survive a hold.
  task automatic runBeats(input int f, input int hold, input bit readyAfter, input bit ovfExp);
    for (int k = 0; k < OUT_BEATS; k++) begin
      conv_valid_i = 1'b1;
      conv_i       = beatPattern(f, k);
      out_ready    = (k >= hold);
      frame_req    = (k == 10);
      if (k >= hold || k < 4) outQ.push_back(beatPattern(f, k));
      @(negedge clk);
      checkOutput("sta_run", 320'(sta_o), 320'(1));
      checkOutput("done_pulse", 320'(done_o), 320'(k == OUT_BEATS - 1));
      @(posedge clk);
      #1;
    end
    conv_valid_i = 1'b0;
    frame_req    = 1'b0;
    out_ready    = readyAfter;
    @(negedge clk);
    checkOutput("busy_fall", 320'(busy_o), 320'(0));
    checkOutput("sta_fall", 320'(sta_o), 320'(0));
    checkOutput("done_low", 320'(done_o), 320'(0));
    checkOutput("ovf_flag", 320'(ovf_o), 320'(ovfExp));
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset();
    checkOutput("rst_cfg_ready", 320'(cfg_ready), 320'(0));
    checkOutput("rst_scan", 320'(scan_o), 320'(SCAN_IDLE));
    checkOutput("rst_bias", 320'(bias_o), 320'(BIAS_IDLE));
    checkOutput("rst_sta", 320'(sta_o), 320'(0));
    checkOutput("rst_out_valid", 320'(out_valid), 320'(0));
    checkOutput("rst_out_data", out_data, 320'(0));
    checkOutput("rst_done", 320'(done_o), 320'(0));
    checkOutput("rst_ovf", 320'(ovf_o), 320'(0));
    checkOutput("rst_busy", 320'(busy_o), 320'(0));
  endtask

  // Monitor: every cycle out of reset, consume whatever the DUT presents.
  initial begin
    logic [39:0]  expScan;
    logic [23:0]  expBias;
    logic [319:0] expOut;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (scan_o[6:0] != 7'h7F) begin
          if (scanQ.size() == 0) begin
            checkOutput("scan_unexpected", 320'(scan_o), 320'(SCAN_IDLE));
          end else begin
            expScan = scanQ.pop_front();
            checkOutput("scan_write", 320'(scan_o), 320'(expScan));
          end
        end else begin
          checkOutput("scan_idle", 320'(scan_o), 320'(SCAN_IDLE));
        end
        if (bias_o[5:0] != 6'h3F) begin
          if (biasQ.size() == 0) begin
            checkOutput("bias_unexpected", 320'(bias_o), 320'(BIAS_IDLE));
          end else begin
            expBias = biasQ.pop_front();
            checkOutput("bias_write", 320'(bias_o), 320'(expBias));
          end
        end else begin
          checkOutput("bias_idle", 320'(bias_o), 320'(BIAS_IDLE));
        end
        if (out_valid && out_ready) begin
          if (outQ.size() == 0) begin
            checkOutput("out_unexpected", out_data, 320'(0));
          end else begin
            expOut = outQ.pop_front();
            checkOutput("out_beat", out_data, expOut);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
`ifdef CONV_1ST_SCHED_OVF_EN
    ovfDropExpect = 1'b1;
`else
    ovfDropExpect = 1'b0;
`endif
    testsRun     = 0;
    testsFailed  = 0;
    rst_n        = 1'b0;
    frame_req    = 1'b0;
    bias_reload  = 1'b0;
    cfg_valid    = 1'b0;
    cfg_data     = '0;
    conv_valid_i = 1'b0;
    conv_i       = '0;
    out_ready    = 1'b0;

    repeat (3) @(negedge clk);
    checkReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Frame 1: bias reload, back-to-back words, full-rate drain.
    loadFrame(1, 1'b1, 1'b0, PIX_WORDS);
    checkStart();
    runBeats(1, 0, 1'b1, 1'b0);

    // Frame 2: no bias, gapped host words; fill FIFO then push+pop while full.
    loadFrame(2, 1'b0, 1'b1, PIX_WORDS);
    checkStart();
    runBeats(2, 4, 1'b1, 1'b0);

    // Frame 3: stall for 6 beats so beats 4 and 5 are dropped.
    loadFrame(3, 1'b0, 1'b0, PIX_WORDS);
    checkStart();
    runBeats(3, 6, 1'b0, ovfDropExpect);

    // Frame 4: FIFO still holds frame 3 beats; reset during word 40.
    loadFrame(4, 1'b0, 1'b0, 40);
    cfg_valid = 1'b1;
    cfg_data  = pixWord(4, 40);
    rst_n     = 1'b0;
    @(negedge clk);
    checkReset();
    scanQ.delete();
    biasQ.delete();
    outQ.delete();
    cfg_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Frame 5: loads from pointer 0 after the abort.
    loadFrame(5, 1'b0, 1'b0, PIX_WORDS);
    checkStart();
    runBeats(5, 0, 1'b1, 1'b0);
    repeat (6) @(posedge clk);
    #1;

    checkOutput("scan_queue_drained", 320'(scanQ.size()), 320'(0));
    checkOutput("bias_queue_drained", 320'(biasQ.size()), 320'(0));
    checkOutput("out_queue_drained", 320'(outQ.size()), 320'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/conv_1st_sched.md
# conv_1st_sched

Frame scheduler for the first-layer convolution engine. It accepts configuration words from a host valid/ready stream and turns them into the engine's pointer-tagged scan-chain writes: bias/scale/shift words (optional per frame), then 75 packed-pixel words. It then holds the engine start level for the frame, collects the engine's output beats into a small FIFO, and drains them to a downstream consumer under valid/ready backpressure. It sits between the host/DMA interface and the first-layer convolution top.

## Interface
Parameters:
- PIX_WORDS, 75: pixel words per frame (4 pixels per 32-bit word).
- BIAS_WORDS, 34: bias words per reload (32 channel biases, then scale, then shift).
- OUT_BEATS, 32: engine output beats per frame.
- OFIFO_DEPTH, 4: output FIFO depth (power of two, ≥2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- frame_req  in  1  start-frame request; accepted only in IDLE
- bias_reload  in  1  sampled with frame_req; 1 means load BIAS_WORDS words before the pixels
- busy_o  out  1  high whenever the state is not IDLE
- cfg_valid  in  1  host word valid
- cfg_ready  out  1  host word ready
- cfg_data  in  32  host word; bias words use [15:0]
- scan_o  out  40  to engine scan input: {data[31:0], 1'b0, ptr[6:0]}
- bias_o  out  24  to engine bias input: {data[15:0], 2'b0, ptr[5:0]}
- sta_o  out  1  engine start level
- conv_valid_i  in  1  engine output beat valid
- conv_i  in  320  engine output beat (40 × 8-bit)
- out_valid  out  1  downstream beat valid
- out_ready  in  1  downstream ready
- out_data  out  320  downstream beat
- done_o  out  1  one-cycle pulse at frame completion
- ovf_o  out  1  sticky overflow flag (see Configuration)

## Operation
- States: IDLE, LOAD_BIAS, LOAD_PIX, SETTLE, RUN.
- IDLE: if frame_req=1, latch bias_reload and go to LOAD_BIAS if it is 1, otherwise LOAD_PIX. The word counter clears on this transition.
- LOAD_BIAS: cfg_ready=1. Word k (k=0..BIAS_WORDS-1) is written as bias_o={cfg_data[15:0],2'b0,k}. After word BIAS_WORDS-1 is accepted, clear the counter and go to LOAD_PIX.
- LOAD_PIX: cfg_ready=1. Word k is written as scan_o={cfg_data,1'b0,k}. After word PIX_WORDS-1 is accepted, go to SETTLE.
- SETTLE: one cycle so the last engine buffer write lands, then go to RUN.
- RUN: sta_o=1. Each conv_valid_i beat pushes conv_i into the FIFO and increments the beat counter. When beat OUT_BEATS-1 is pushed, pulse done_o in that cycle and go to IDLE the next cycle. The FIFO keeps draining after the return to IDLE.
- cfg_ready=0 outside the LOAD states, so host words are never consumed there.
- Idle pointers: whenever no write is issued, scan_o ptr=7'h7F and bias_o ptr=6'h3F. Both are out of range, so no engine buffer entry is written. Idle data fields are 0.
- FIFO: out_valid = not empty; pop on out_valid&&out_ready. A simultaneous push and pop on a full FIFO is legal and loses nothing. A push while the FIFO is full with no pop in the same cycle drops the beat.
- frame_req outside IDLE is ignored.
- A new frame may start while the FIFO still holds beats from the previous frame.

## Timing
- Reset values: cfg_ready=0, scan_o={32'b0,1'b0,7'h7F}, bias_o={16'b0,2'b0,6'h3F}, sta_o=0, out_valid=0, out_data=0, done_o=0, ovf_o=0, busy_o=0, state=IDLE, all counters 0, FIFO empty.
- Assertion of rst_n mid-frame aborts the frame immediately and flushes the FIFO.
- scan_o, bias_o and sta_o are registered: a word accepted in cycle t appears on scan_o/bias_o in cycle t+1, for one cycle only.
- From frame_req with bias_reload=0 to the first sta_o=1 cycle: the host pushes PIX_WORDS words back-to-back, then +2 cycles (register stage plus SETTLE).
- FIFO latency from push to out_valid is 1 cycle. out_data is registered from the FIFO head.
- Counter widths: 7-bit word counter, ⌈log2(OUT_BEATS+1)⌉-bit beat counter.

## Configuration
- CONV_1ST_SCHED_OVF_EN defined: a dropped beat sets ovf_o, which stays set until reset. A dropped beat also forces done_o and the IDLE return at the normal beat count, so frame sequencing is unaffected.
- CONV_1ST_SCHED_OVF_EN undefined: ovf_o is tied 0 and no detection logic is built. Drop behaviour is unchanged.

## Structure
- Shared package conv_1st_pkg holds:
  - the state enum;
  - the idle pointer constants SCAN_PTR_IDLE=7'h7F and BIAS_PTR_IDLE=6'h3F;
  - the word-width constants (pixel word 32, bias 16, beat 320).
- One sub-module: conv_1st_ofifo, a parameterized synchronous FIFO (width 320, depth OFIFO_DEPTH) with full/empty outputs and asynchronous reset.

## Test plan
- Reset, then frame_req with bias_reload=1 and 34+75 back-to-back words → bias_o ptrs 0..33, then scan_o ptrs 0..74, each with the matching data, then sta_o=1 two cycles after the last scan write.
- bias_reload=0 and cfg_valid toggled every other cycle → no bias_o writes, scan ptrs contiguous 0..74, idle cycles show ptr 7'h7F.
- RUN with 32 conv_valid_i beats carrying pattern k and out_ready=1 → 32 out_data beats in order, done_o pulses with beat 31, busy_o falls the next cycle.
- out_ready=0 during 6 beats at depth 4 → the first 4 beats are retained, beats 5 and 6 are dropped, and ovf_o=1 (macro defined) or 0 (undefined). done_o still pulses at beat 32.
- Simultaneous push and pop on a full FIFO → no loss, ovf_o stays 0.
- rst_n asserted mid-LOAD_PIX at word 40 → all outputs return to their reset values. A following frame loads correctly from ptr 0.
